// File: rtl/fetch_stage.sv
// fetch_stage: RV32 fetch stage that owns the PC and the IF/ID register and handles stall, redirect and halt.
// Optional static JAL prediction is enabled by `define FETCH_JAL_PRED_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013,
    parameter logic [31:0] HALT_INST = 32'h0000_007F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    input  logic [31:0] inst_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_inst_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_pc4_o,
    output logic        ifid_pred_taken_o,
    output logic        halted_o
);
    typedef enum logic {RUN, HALTED} state_t;
    state_t state, state_nx;
    logic [31:0] pc_nx, inst_nx, ifpc_nx, seq_pc;
    logic        valid_nx, pred_nx, take;
`ifdef FETCH_JAL_PRED_EN
    assign take   = inst_i[6:0] == 7'b1101111;
    assign seq_pc = take ? pc_o + {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}
                         : pc_o + 32'd4;
`else
    assign take   = 1'b0;
    assign seq_pc = pc_o + 32'd4;
`endif
    assign ifid_pc4_o = ifid_pc_o + 32'd4;
    assign halted_o   = state == HALTED;
    always_comb begin
        state_nx = state;
        pc_nx    = pc_o;
        valid_nx = ifid_valid_o;
        inst_nx  = ifid_inst_o;
        ifpc_nx  = ifid_pc_o;
        pred_nx  = ifid_pred_taken_o;
        // a redirect squashes everything younger, including a wrong-path halt
        if (redirect_i) begin
            pc_nx    = {redirect_pc_i[31:2], 2'b00};
            valid_nx = 1'b0;
            inst_nx  = NOP_INST;
            pred_nx  = 1'b0;
            state_nx = RUN;
        end else if (!stall_i) begin
            if (state == HALTED) begin
                valid_nx = 1'b0;
                inst_nx  = NOP_INST;
                pred_nx  = 1'b0;
            end else begin
                valid_nx = 1'b1;
                inst_nx  = inst_i;
                ifpc_nx  = pc_o;
                pred_nx  = inst_i == HALT_INST ? 1'b0 : take;
                pc_nx    = inst_i == HALT_INST ? pc_o : seq_pc;
                state_nx = inst_i == HALT_INST ? HALTED : RUN;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= RUN;
            pc_o              <= RESET_PC;
            ifid_valid_o      <= 1'b0;
            ifid_inst_o       <= NOP_INST;
            ifid_pc_o         <= 32'd0;
            ifid_pred_taken_o <= 1'b0;
        end else begin
            state             <= state_nx;
            pc_o              <= pc_nx;
            ifid_valid_o      <= valid_nx;
            ifid_inst_o       <= inst_nx;
            ifid_pc_o         <= ifpc_nx;
            ifid_pred_taken_o <= pred_nx;
        end
    end
endmodule
